inv_share_arbiter: RTL and testbench
====================================

Name: inv_share_arbiter

Overview:
Shares a single inverter datapath (module1 style, out = ~in, widened to W bits) among N requesters using round-robin arbitration with valid/ready handshakes.
- Optionally configures the unit as pass-through.
- Registers the result into a single output stage, tagged with the requester ID.
- Sits between several producer blocks and one consumer in testbench/demo designs that need a shared transform resource.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width of each request and of the result
ID_W, 2, width of requester index; must equal clog2(N), checked at elaboration
CNT_W, 16, width of completed-transaction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset
req_valid  input  N  per-requester request valid
req_data  input  N*W  request data, requester i at bits [i*W +: W]
req_ready  output  N  one-hot grant/ready, at most one bit high
cfg_invert  input  1  1 = invert data, 0 = pass through; sampled at acceptance
out_valid  output  1  result valid
out_data  output  W  result data
out_id  output  ID_W  index of requester that produced the result
out_ready  input  1  consumer ready
done_count  output  CNT_W  number of results consumed (out_valid && out_ready), wraps

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_id=0, done_count=0.
  - Priority pointer = 0, so requester 0 has highest priority first.
  - req_ready=0 while rst is high.
- Output stage:
  - "Free" = !out_valid || out_ready.
  - req_ready is combinational from req_valid, the pointer and free.
  - When free, req_ready[g]=1 for the winner g: the first i with req_valid[i]=1, searching from pointer upward, mod N.
  - When not free, or no req_valid is set, req_ready=0.
- Acceptance: req_valid[g] && req_ready[g]. On the next edge:
  - out_data <= cfg_invert ? ~req_data[g] : req_data[g]
  - out_id <= g, out_valid <= 1
  - pointer <= (g+1) mod N
- Latency and throughput:
  - Latency is 1 cycle from acceptance to out_valid.
  - Throughput is 1 per cycle when out_ready stays high (accept and drain in the same cycle).
- Stall: while out_valid && !out_ready, out_data/out_id/out_valid hold stable and the pointer does not move.
- Drain without new accept: out_valid && out_ready with no acceptance → out_valid <= 0. out_data and out_id keep their last value.
- done_count increments by 1 on every out_valid && out_ready edge and wraps at 2^CNT_W−1 → 0.
- Requester behaviour: a requester may deassert req_valid without being granted; nothing is consumed. A requester must hold its data stable while valid.
- Pointer wrap: after a grant to N−1, the pointer goes to 0.
- Single requester: a sole active requester is granted every free cycle regardless of pointer.
- Reset mid-operation: a held, unconsumed result is discarded. No done_count increment even if out_ready=1 in the rst cycle.
- cfg_invert changing mid-stall does not alter an already registered result.

Decomposition:
- Shared package constants: DEF_N=4, DEF_W=8, and a clog2 function for ID_W checking.
- Sub-module inv_unit (W-bit, combinational, output = invert ? ~in : in): the shared datapath, instantiated once by name.
- Arbiter logic (round-robin pick) stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 → req_ready=0, out_valid=0, done_count=0. First grant after release goes to requester 0.
- Round-robin fairness: req_valid=4'b1111, cfg_invert=1, data i = 8'h10+i, out_ready=1 → out_id sequence 0,1,2,3,0; out_data EF,EE,ED,EC; one result per cycle; done_count=5 after 5 results.
- Back-pressure: out_ready=0 for 3 cycles after first result (id 0, data 8'hA5 → 8'h5A) → out_data/out_id held, req_ready=0. On release, next grant goes to requester 1.
- Pass-through and pointer wrap: only req_valid[3]=1, data 8'h3C, cfg_invert=0 → out_data=8'h3C, out_id=3. Then requesters 0 and 2 both valid → requester 0 granted first.
- Counter wrap: CNT_W=4, 17 consumed results → done_count=1.
- Mid-operation reset: out_valid=1, out_ready=0, assert rst one cycle → out_valid=0, done_count unchanged at 0. Pointer back to 0.

Source files
------------

// File: rtl/inv_share_arbiter_pkg.sv
// Shared constants and helpers for the round-robin inverter-sharing arbiter.
// Imported by the top level and by the shared datapath unit.
package inv_share_arbiter_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_ID_W  = 2;
  localparam int DEF_CNT_W = 16;

  // Smallest r with 2**r >= value; used to validate the requester index width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_share_arbiter_inv_unit.sv
// Shared W-bit transform: bitwise inversion or pass-through, purely combinational.
module inv_unit #(
  parameter int W = 8
) (
  input  logic         invert_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  assign data_o = invert_i ? ~data_i : data_i;

endmodule

// File: rtl/inv_share_arbiter.sv
// Round-robin arbiter that shares one inverter among N valid/ready requesters
// and registers the tagged result in a single output stage.
module inv_share_arbiter
  import inv_share_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int ID_W  = DEF_ID_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  input  logic             cfg_invert,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [ID_W-1:0]  out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_count
);

  if ((ID_W != clog2(N)) || (N < 2) || (N > 8)) begin : g_param_check
    $error("inv_share_arbiter: N must be 2..8 and ID_W must equal clog2(N)");
  end

  logic             outValid_q, outValid_d;
  logic [W-1:0]     outData_q, outData_d;
  logic [ID_W-1:0]  outId_q, outId_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] doneCount_q, doneCount_d;

  logic             free;
  logic             found;
  logic [ID_W-1:0]  win;
  logic [W-1:0]     selData;
  logic [W-1:0]     xformData;
  logic             accept;
  logic             drain;

  assign free  = !outValid_q || out_ready;
  assign drain = outValid_q && out_ready;

  // Search from the pointer upward, wrapping modulo N; first valid requester wins.
  always_comb begin : p_pick
    int idx;
    found   = 1'b0;
    win     = '0;
    selData = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win     = ID_W'(idx);
        selData = req_data[idx*W +: W];
      end
    end
  end

  assign accept = found && free && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win] = 1'b1;
    end
  end

  inv_unit #(
    .W (W)
  ) u_inv_unit (
    .invert_i (cfg_invert),
    .data_i   (selData),
    .data_o   (xformData)
  );

  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outId_d     = outId_q;
    ptr_d       = ptr_q;
    doneCount_d = doneCount_q;
    if (drain) begin
      doneCount_d = doneCount_q + CNT_W'(1);
    end
    if (accept) begin
      outValid_d = 1'b1;
      outData_d  = xformData;
      outId_d    = win;
      ptr_d      = (win == ID_W'(N - 1)) ? '0 : win + ID_W'(1);
    end else if (drain) begin
      // Data and id deliberately keep their last value after a drain.
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outId_q     <= '0;
      ptr_q       <= '0;
      doneCount_q <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outId_q     <= outId_d;
      ptr_q       <= ptr_d;
      doneCount_q <= doneCount_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_id     = outId_q;
  assign done_count = doneCount_q;

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Self-checking bench for inv_share_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_inv_share_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     reqValid;
  logic [N*W-1:0]   reqData;
  logic [N-1:0]     reqReady;
  logic             cfgInvert;
  logic             outValid;
  logic [W-1:0]     outData;
  logic [ID_W-1:0]  outId;
  logic             outReady;
  logic [CNT_W-1:0] doneCount;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model state
  bit           mValid;
  logic [W-1:0] mData;
  int           mId;
  int           mPtr;
  int           mCount;
  int           lastGrant;

  inv_share_arbiter #(
    .N     (N),
    .W     (W),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_data   (reqData),
    .req_ready  (reqReady),
    .cfg_invert (cfgInvert),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_id     (outId),
    .out_ready  (outReady),
    .done_count (doneCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickWinner();
    for (int k = 0; k < N; k++) begin
      if (reqValid[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expectedReady();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = pickWinner();
    if (!rst && (!mValid || outReady) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // One clock: check grant, advance model at the edge, check the registered outputs.
  task automatic applyStimulus();
    int g;
    bit fire;
    logic [W-1:0] d;
    #1;
    checkOutput("req_ready", 32'(reqReady), 32'(expectedReady()));
    g = pickWinner();
    @(posedge clk);
    lastGrant = -1;
    if (rst) begin
      mValid = 0; mData = '0; mId = 0; mPtr = 0; mCount = 0;
    end else begin
      fire = mValid && outReady;
      if (fire) mCount = (mCount + 1) % (1 << CNT_W);
      if ((!mValid || outReady) && g >= 0) begin
        d = reqData[g*W +: W];
        mData = cfgInvert ? ~d : d;
        mId = g; mValid = 1; mPtr = (g + 1) % N;
        lastGrant = g;
      end else if (fire) begin
        mValid = 0;
      end
    end
    #1;
    checkOutput("out_valid", 32'(outValid), 32'(mValid));
    checkOutput("out_data", 32'(outData), 32'(mData));
    checkOutput("out_id", 32'(outId), 32'(mId));
    checkOutput("done_count", 32'(doneCount), 32'(mCount));
    @(negedge clk);
  endtask

  task automatic setData(input int i, input logic [W-1:0] v);
    reqData[i*W +: W] = v;
  endtask

  task automatic doReset();
    rst = 1; reqValid = '0; outReady = 0;
    applyStimulus();
    rst = 0;
  endtask

  initial begin
    rst = 1; reqValid = '1; reqData = '0; cfgInvert = 0; outReady = 0;
    mValid = 0; mData = '0; mId = 0; mPtr = 0; mCount = 0; lastGrant = -1;
    @(negedge clk);

    // Reset held with every requester asking
    applyStimulus();
    applyStimulus();
    checkOutput("rst_ready", 32'(reqReady), 32'h0);
    checkOutput("rst_valid", 32'(outValid), 32'h0);
    checkOutput("rst_count", 32'(doneCount), 32'h0);

    // Round-robin fairness with inversion
    rst = 0; reqValid = 4'b1111; cfgInvert = 1; outReady = 1;
    for (int i = 0; i < N; i++) setData(i, 8'h10 + 8'(i));
    applyStimulus(); checkOutput("rr_id0", 32'(outId), 0); checkOutput("rr_d0", 32'(outData), 32'hEF);
    applyStimulus(); checkOutput("rr_id1", 32'(outId), 1); checkOutput("rr_d1", 32'(outData), 32'hEE);
    applyStimulus(); checkOutput("rr_id2", 32'(outId), 2); checkOutput("rr_d2", 32'(outData), 32'hED);
    applyStimulus(); checkOutput("rr_id3", 32'(outId), 3); checkOutput("rr_d3", 32'(outData), 32'hEC);
    applyStimulus(); checkOutput("rr_id4", 32'(outId), 0); checkOutput("rr_d4", 32'(outData), 32'hEF);
    reqValid = '0;
    applyStimulus();
    checkOutput("rr_count", 32'(doneCount), 5);

    // Back-pressure holds the result and freezes the pointer
    doReset();
    reqValid = 4'b0001; setData(0, 8'hA5); cfgInvert = 1; outReady = 1;
    applyStimulus();
    checkOutput("bp_first", 32'(outData), 32'h5A);
    reqValid = 4'b1111; outReady = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("bp_hold_d", 32'(outData), 32'h5A);
      checkOutput("bp_hold_id", 32'(outId), 0);
      checkOutput("bp_ready", 32'(reqReady), 0);
    end
    outReady = 1;
    #1;
    checkOutput("bp_next", 32'(reqReady), 32'b0010);
    applyStimulus();

    // Pass-through and pointer wrap
    doReset();
    reqValid = 4'b1000; setData(3, 8'h3C); cfgInvert = 0; outReady = 1;
    applyStimulus();
    checkOutput("pt_data", 32'(outData), 32'h3C);
    checkOutput("pt_id", 32'(outId), 3);
    reqValid = 4'b0101;
    #1;
    checkOutput("wrap_grant", 32'(reqReady), 32'b0001);
    applyStimulus();

    // Counter wrap: 17 consumed results in a 4-bit counter
    doReset();
    reqValid = 4'b0001; outReady = 1;
    for (int c = 0; c < 17; c++) begin
      cfgInvert = 1'($urandom);
      setData(0, 8'($urandom));
      applyStimulus();
    end
    reqValid = '0;
    applyStimulus();
    checkOutput("cnt_wrap", 32'(doneCount), 1);

    // Reset in the middle of a stalled result
    doReset();
    reqValid = 4'b0100; outReady = 0;
    applyStimulus();
    rst = 1; outReady = 1;
    applyStimulus();
    checkOutput("mid_valid", 32'(outValid), 0);
    checkOutput("mid_count", 32'(doneCount), 0);
    rst = 0; reqValid = 4'b1111;
    #1;
    checkOutput("mid_ptr", 32'(reqReady), 32'b0001);
    applyStimulus();

    // Randomized traffic: requesters hold data while valid, may withdraw
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqValid[i] || lastGrant == i) begin
          reqValid[i] = ($urandom_range(0, 99) < 55);
          setData(i, 8'($urandom));
        end else if ($urandom_range(0, 99) < 5) begin
          reqValid[i] = 1'b0;
        end
      end
      outReady  = ($urandom_range(0, 99) < 70);
      cfgInvert = 1'($urandom);
      rst       = ($urandom_range(0, 99) < 2);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
